// File: rtl/calc_entry.sv
// -----------------------------------------------------------------------------
// calc_entry
//   Keypad entry front end for a two-operand calculator. Collects two decimal
//   operands of up to two digits each plus an operator key code, and hands
//   them to a downstream arithmetic stage. Performs no arithmetic itself.
//
//   Flow: ENT_A (enter A digits, then an operator)
//         -> ENT_B (enter B digits, the operator may still change)
//         -> DONE  (KEY_EQ pressed; the operands are presented as stable)
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   key_valid    in   1  high while a key is pressed
//   key_code     in   8  code of the pressed key, stable while key_valid is high
//   A1, A0       out  8  operand A tens / units digit (0-9)
//   B1, B0       out  8  operand B tens / units digit (0-9)
//   OP           out  8  latched operator key code
//   calc_rst     out  1  high while the operands are incomplete (not DONE)
//   result_valid out  1  one-cycle pulse when the expression completes
//   phase        out  2  state encoding for the display (0 ENT_A, 1 ENT_B, 2 DONE)
// -----------------------------------------------------------------------------
module calc_entry #(
   parameter logic [7:0] KEY_ADD = 8'h0A,
   parameter logic [7:0] KEY_SUB = 8'h0B,
   parameter logic [7:0] KEY_MUL = 8'h0F,
   parameter logic [7:0] KEY_CLR = 8'h0C,
   parameter logic [7:0] KEY_EQ  = 8'h0E
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   output logic [7:0] A1,
   output logic [7:0] A0,
   output logic [7:0] B1,
   output logic [7:0] B0,
   output logic [7:0] OP,
   output logic       calc_rst,
   output logic       result_valid,
   output logic [1:0] phase
);

   typedef enum logic [1:0] {
      ENT_A = 2'd0,
      ENT_B = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] a1_q, a1_d, a0_q, a0_d;
   logic [7:0] b1_q, b1_d, b0_q, b0_d;
   logic [7:0] op_q, op_d;
   logic       a_seen_q, a_seen_d;     // at least one A digit entered
   logic       b_seen_q, b_seen_d;     // at least one B digit entered
   logic       calc_rst_q, calc_rst_d;
   logic       result_valid_q, result_valid_d;
   logic       key_prev_q;             // key_valid from the previous cycle
   logic       armed_q;                // key_valid has been seen low since reset

   logic key_evt, is_digit, is_op;

   // A key held across reset release must not count: the edge detector only
   // arms once key_valid has been observed low.
   assign key_evt  = key_valid && !key_prev_q && armed_q;
   assign is_digit = (key_code <= 8'h09);
   assign is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB) ||
                     (key_code == KEY_MUL);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ENT_A;
         a1_q           <= 8'h00;
         a0_q           <= 8'h00;
         b1_q           <= 8'h00;
         b0_q           <= 8'h00;
         op_q           <= 8'h00;
         a_seen_q       <= 1'b0;
         b_seen_q       <= 1'b0;
         calc_rst_q     <= 1'b1;
         result_valid_q <= 1'b0;
         key_prev_q     <= 1'b0;
         armed_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         a1_q           <= a1_d;
         a0_q           <= a0_d;
         b1_q           <= b1_d;
         b0_q           <= b0_d;
         op_q           <= op_d;
         a_seen_q       <= a_seen_d;
         b_seen_q       <= b_seen_d;
         calc_rst_q     <= calc_rst_d;
         result_valid_q <= result_valid_d;
         key_prev_q     <= key_valid;
         if (!key_valid) armed_q <= 1'b1;
      end
   end

   // NOTE: every signal written here gets its default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d        = state_q;
      a1_d           = a1_q;
      a0_d           = a0_q;
      b1_d           = b1_q;
      b0_d           = b0_q;
      op_d           = op_q;
      a_seen_d       = a_seen_q;
      b_seen_d       = b_seen_q;
      result_valid_d = 1'b0;

      if (key_evt) begin
         if (key_code == KEY_CLR) begin
            state_d  = ENT_A;
            a1_d     = 8'h00;
            a0_d     = 8'h00;
            b1_d     = 8'h00;
            b0_d     = 8'h00;
            op_d     = 8'h00;
            a_seen_d = 1'b0;
            b_seen_d = 1'b0;
         end else begin
            unique case (state_q)
               ENT_A: begin
                  if (is_digit) begin
                     a1_d     = a0_q;
                     a0_d     = key_code;
                     a_seen_d = 1'b1;
                  end else if (is_op && a_seen_q) begin
                     op_d    = key_code;
                     state_d = ENT_B;
                  end
               end
               ENT_B: begin
                  if (is_digit) begin
                     b1_d     = b0_q;
                     b0_d     = key_code;
                     b_seen_d = 1'b1;
                  end else if (is_op && !b_seen_q) begin
                     op_d = key_code;
                  end else if ((key_code == KEY_EQ) && b_seen_q) begin
                     state_d        = DONE;
                     result_valid_d = 1'b1;
                  end
               end
               DONE: begin
                  // A digit starts a fresh expression; operators and EQ hold.
                  if (is_digit) begin
                     state_d  = ENT_A;
                     a1_d     = 8'h00;
                     a0_d     = key_code;
                     b1_d     = 8'h00;
                     b0_d     = 8'h00;
                     op_d     = 8'h00;
                     a_seen_d = 1'b1;
                     b_seen_d = 1'b0;
                  end
               end
               default: state_d = ENT_A;
            endcase
         end
      end

      // Registered so calc_rst flips on the same edge as the state.
      calc_rst_d = (state_d != DONE);
   end

   assign A1           = a1_q;
   assign A0           = a0_q;
   assign B1           = b1_q;
   assign B0           = b0_q;
   assign OP           = op_q;
   assign calc_rst     = calc_rst_q;
   assign result_valid = result_valid_q;
   assign phase        = state_q;

endmodule

// File: doc/calc_entry.md
CALC_ENTRY -- requirements
Module: calc_entry

Parameters
REQ-001 The block SHALL have parameter KEY_ADD, default 8'h0A, the key code for the add operator.
REQ-002 The block SHALL have parameter KEY_SUB, default 8'h0B, the key code for the subtract operator.
REQ-003 The block SHALL have parameter KEY_MUL, default 8'h0F, the key code for the multiply operator.
REQ-004 The block SHALL have parameter KEY_CLR, default 8'h0C, the key code for clear.
REQ-005 The block SHALL have parameter KEY_EQ, default 8'h0E, the key code for equals.

Interface
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL have port clk, input, 1 bit: the system clock, rising edge active.
REQ-008 The block SHALL have port rst_n, input, 1 bit: the asynchronous active-low reset.
REQ-009 The block SHALL have port key_valid, input, 1 bit: high while a key is pressed.
REQ-010 The block SHALL have port key_code, input, 8 bits: the code of the pressed key, stable while key_valid is high.
REQ-011 The block SHALL have ports A1, A0, B1, B0, output, 8 bits each: operand tens and units digits (0-9), fed to the arithmetic stage.
REQ-012 The block SHALL have port OP, output, 8 bits: the latched operator key code.
REQ-013 The block SHALL have port calc_rst, output, 1 bit: high when the operands are incomplete; it drives the arithmetic stage's rst.
REQ-014 The block SHALL have port result_valid, output, 1 bit: a one-cycle pulse when the expression is complete.
REQ-015 The block SHALL have port phase, output, 2 bits: current state encoding, for the display.

Function
REQ-016 The block SHALL act only on the rising edge of key_valid, registered in clk; a key held for N cycles SHALL count as one key event.
REQ-017 Key classes SHALL be: digit when key_code is 8'h00-8'h09; operator when key_code is KEY_ADD, KEY_SUB or KEY_MUL; KEY_CLR; KEY_EQ; any other code SHALL be ignored.
REQ-018 The states SHALL be ENT_A (phase 2'd0), ENT_B (phase 2'd1) and DONE (phase 2'd2).
REQ-019 A digit event SHALL shift into the active operand: tens <= units, units <= digit; on a third or later digit the oldest digit SHALL be discarded.
REQ-020 In ENT_A, an operator event SHALL be accepted only after at least one A digit: it latches OP and moves to ENT_B; otherwise it SHALL be ignored.
REQ-021 In ENT_B, a further operator event SHALL overwrite OP only while no B digit has been entered; after that it SHALL be ignored.
REQ-022 In ENT_B, KEY_EQ SHALL be accepted only after at least one B digit: the block moves to DONE, and result_valid pulses high for exactly one cycle, in the cycle after the event is detected.
REQ-023 KEY_EQ SHALL be ignored in ENT_A and in DONE.
REQ-024 In DONE, all outputs SHALL hold and calc_rst SHALL be 0.
REQ-025 In DONE, a digit event SHALL clear A, B and OP, load the digit into A0 and move to ENT_A.
REQ-026 In DONE, operator events SHALL be ignored.
REQ-027 KEY_CLR in any state SHALL clear every operand and OP to 8'h00 and move to ENT_A, synchronously.
REQ-028 calc_rst SHALL be 1 in ENT_A and ENT_B, and 0 only in DONE.
REQ-029 All outputs SHALL be registered, and the state change SHALL be visible one clk after the edge of the key event.
REQ-030 A key event and KEY_CLR cannot coincide; only one key_code is presented at a time.
REQ-031 Operand range SHALL be 0-99, so the downstream product is at most 9801 and fits in 14 bits; the block performs no arithmetic.

Reset
REQ-032 While rst_n is low, asynchronously: state SHALL be ENT_A; A1, A0, B1, B0 and OP SHALL be 8'h00; calc_rst SHALL be 1; result_valid SHALL be 0; phase SHALL be 2'd0; the edge-detect register SHALL be 0.
REQ-033 After reset release, a key_valid that is already high SHALL NOT generate an event until it falls and rises again.
REQ-034 Reset asserted mid-entry SHALL discard any partial expression.

Verification
REQ-035 The bench SHALL cover: keys 1,2,KEY_ADD,3,4,KEY_EQ -> A1=1, A0=2, OP=8'h0A, B1=3, B0=4, one result_valid pulse, calc_rst=0, phase=2; the downstream output is 46.
REQ-036 The bench SHALL cover: keys 7,8,9 in ENT_A -> A1=8, A0=9, phase=0, calc_rst=1.
REQ-037 The bench SHALL cover: KEY_MUL first, then 5, KEY_EQ, KEY_SUB, KEY_EQ -> the first operator and the first KEY_EQ are ignored; OP=8'h0B; phase=1, because the second KEY_EQ comes with no B digit.
REQ-038 The bench SHALL cover: digit 5 held high for 6 cycles -> A0=5 and A1=0, a single event.
REQ-039 The bench SHALL cover: KEY_CLR during ENT_B with A=42 and B=7 -> all operands 0, phase=0, no result_valid.
REQ-040 The bench SHALL cover: rst_n pulsed low mid-clock during ENT_B -> the outputs reach their reset values immediately, without a clk edge.
